// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle short/long/repeat events plus a held level.
// Optional auto-repeat while held is compiled in with `define BTN_AUTO_REPEAT_EN.
module btn_event_decoder #(
    parameter int LONG_PRESS    = 10_000_000,
    parameter int REPEAT_PERIOD = 2_000_000,
    parameter int CNT_W         = 24
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);

    // Illegal parameter sets are caught at elaboration rather than misbehaving silently
    if ((LONG_PRESS < 2) || (REPEAT_PERIOD < 2) ||
        (longint'(LONG_PRESS - 1) >= (64'sd1 <<< CNT_W)) ||
        (longint'(REPEAT_PERIOD - 1) >= (64'sd1 <<< CNT_W))) begin : g_param_check
        $error("btn_event_decoder: illegal LONG_PRESS/REPEAT_PERIOD/CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic             repeat_q, repeat_d;
`endif

    // Next-state, counter and pulse decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_btn) begin
                    state_d = ST_PRESSED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                // Release on the terminal count still counts as a short press
                if (!i_btn) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!i_btn) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Repeat pulse register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_short = short_q;
    assign o_long  = long_q;
    assign o_held  = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder (LONG_PRESS=8, REPEAT_PERIOD=4, CNT_W=4).
// The reference model counts consecutive pressed edges and derives events arithmetically.
module tb_btn_event_decoder;

    localparam int LP = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic o_short, o_long, o_repeat, o_held;

    int n_cmp = 0;
    int n_err = 0;

    // model state: whether a press is active and how many pressed edges it has seen
    bit m_active = 1'b0;
    int m_n = 0;
    bit exp_short, exp_long, exp_rep, exp_held;
    int seen_short, seen_long, seen_rep;

    btn_event_decoder #(.LONG_PRESS(LP), .REPEAT_PERIOD(RP), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_short(o_short), .o_long(o_long), .o_repeat(o_repeat), .o_held(o_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(input bit b, input bit r);
        exp_short = 1'b0;
        exp_long  = 1'b0;
        exp_rep   = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_n = 0;
        end else if (!m_active) begin
            if (b) begin
                m_active = 1'b1;
                m_n = 1;
            end
        end else if (!b) begin
            exp_short = (m_n <= LP);
            m_active = 1'b0;
            m_n = 0;
        end else begin
            m_n++;
            exp_long = (m_n == LP + 1);
`ifdef BTN_AUTO_REPEAT_EN
            exp_rep = (m_n > LP + 1) && (((m_n - 1 - LP) % RP) == 0);
`endif
        end
        exp_held = m_active;
    endtask

    task automatic do_edge(input bit b, input bit r);
        btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check("short", o_short, exp_short);
        check("long", o_long, exp_long);
        check("repeat", o_repeat, exp_rep);
        check("held", o_held, exp_held);
        check("onehot", ($countones({o_short, o_long, o_repeat}) <= 1), 1'b1);
        seen_short += int'(o_short);
        seen_long  += int'(o_long);
        seen_rep   += int'(o_repeat);
    endtask

    // One press of n_on pressed edges followed by n_off released edges, with per-press totals
    task automatic press(input int n_on, input int n_off);
        int e_rep;
        seen_short = 0;
        seen_long  = 0;
        seen_rep   = 0;
        for (int i = 0; i < n_on; i++) do_edge(1'b1, 1'b0);
        for (int i = 0; i < n_off; i++) do_edge(1'b0, 1'b0);
        e_rep = 0;
`ifdef BTN_AUTO_REPEAT_EN
        if (n_on > LP + 1) e_rep = (n_on - 1 - LP) / RP;
`endif
        check_int("press_short_cnt", seen_short, (n_on <= LP) ? 1 : 0);
        check_int("press_long_cnt", seen_long, (n_on > LP) ? 1 : 0);
        check_int("press_rep_cnt", seen_rep, e_rep);
    endtask

    initial begin
        // reset held with button pressed, then press recognised on first free edge
        do_edge(1'b1, 1'b1);
        do_edge(1'b1, 1'b1);
        check("rst_held", o_held, 1'b0);
        do_edge(1'b1, 1'b0);
        check("post_rst_held", o_held, 1'b1);
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b0);

        press(3, 2);    // short press
        press(1, 1);    // single-cycle press, then immediate re-press
        press(1, 1);
        press(8, 2);    // release on terminal count: short wins
        press(9, 2);    // just long
        press(21, 2);   // long hold with repeats when enabled
        press(24, 1);

        // reset mid-hold at cnt=5, button still down
        seen_short = 0;
        seen_long  = 0;
        seen_rep   = 0;
        for (int i = 0; i < 6; i++) do_edge(1'b1, 1'b0);
        do_edge(1'b1, 1'b1);
        check_int("midrst_no_pulse", seen_short + seen_long + seen_rep, 0);
        press(9, 2);

        // randomized run with sticky button and rare resets
        for (int i = 0; i < 600; i++) begin
            bit b, r;
            b = ($urandom_range(0, 9) < 8) ? btn : ~btn;
            r = ($urandom_range(0, 99) == 0);
            do_edge(b, r);
        end
        for (int i = 0; i < 20; i++) press($urandom_range(1, 26), $urandom_range(1, 3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
